booth_seq_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier, parametrised successor to the team's 2-bit serial-parallel multiplier. Supports any width N and per-operand signed/unsigned mode. Adds a ready/busy handshake and held results. Sits in the arithmetic datapath library and is driven by a controller through a start/done handshake.

---
 rtl/booth_mult_pkg.sv | 17 +
 rtl/booth_step.sv | 28 ++
 rtl/booth_seq_multiplier.sv | 156 +++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_pkg.sv
// rtl/booth_mult_pkg.sv - shared types and constants for the sequential Booth multiplier
package booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Extra accumulator bits above the 2N-bit product in the MAC option
    localparam int ACC_GUARD = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth iteration: conditional add/sub of A, then arithmetic shift
module booth_step #(
    parameter int N = 8
) (
    input  logic [N+1:0] upper_i,
    input  logic [N:0]   lower_i,
    input  logic         q_i,
    input  logic [N:0]   a_i,
    output logic [N+1:0] upper_o,
    output logic [N:0]   lower_o,
    output logic         q_o
);

    logic [N+1:0] a_ext;
    logic [N+1:0] sum;

    always_comb begin
        a_ext = {a_i[N], a_i};
        case ({lower_i[0], q_i})
            2'b01:   sum = upper_i + a_ext;
            2'b10:   sum = upper_i - a_ext;
            default: sum = upper_i;
        endcase
        // Shifting {sum, lower, q} right by one drops q and replicates the sign
        {upper_o, lower_o, q_o} = {sum[N+1], sum, lower_i};
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - sequential radix-2 Booth multiplier, signed/unsigned per operand
// Optional multiply-accumulate output enabled by defining BOOTH_MAC_EN.
module booth_seq_multiplier
    import booth_mult_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           a_signed,
    input  logic           b_signed,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] result
`ifdef BOOTH_MAC_EN
    ,
    input  logic                     acc_clr,
    output logic [2*N+ACC_GUARD-1:0] acc
`endif
);

    localparam int CW = cnt_width(N);

    state_e           state_q, state_d;
    logic [N:0]       a_q, a_d;
    logic [N+1:0]     upper_q, upper_d;
    logic [N:0]       lower_q, lower_d;
    logic             qm_q, qm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   result_q, result_d;
    logic             done_q, done_d;
    logic             load;

    logic [N+1:0]     step_upper;
    logic [N:0]       step_lower;
    logic             step_q;
    logic [2*N-1:0]   product;

`ifdef BOOTH_MAC_EN
    logic                     sgn_q, sgn_d;
    logic [2*N+ACC_GUARD-1:0] acc_q, acc_d;
`endif

    booth_step #(.N(N)) u_step (
        .upper_i (upper_q),
        .lower_i (lower_q),
        .q_i     (qm_q),
        .a_i     (a_q),
        .upper_o (step_upper),
        .lower_o (step_lower),
        .q_o     (step_q)
    );

    // The exact product fits in 2N bits, so only the low slice of {upper, lower} is kept
    assign product = {upper_q[N-2:0], lower_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        upper_d  = upper_q;
        lower_d  = lower_q;
        qm_d     = qm_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: load = start;
            RUN: begin
                upper_d = step_upper;
                lower_d = step_lower;
                qm_d    = step_q;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = product;
                done_d   = 1'b1;
                state_d  = IDLE;
                load     = start;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            a_d     = {a_signed & a[N-1], a};
            upper_d = '0;
            lower_d = {b_signed & b[N-1], b};
            qm_d    = 1'b0;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            upper_q  <= '0;
            lower_q  <= '0;
            qm_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            upper_q  <= upper_d;
            lower_q  <= lower_d;
            qm_q     <= qm_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q != RUN);
    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;

`ifdef BOOTH_MAC_EN
    always_comb begin
        sgn_d = sgn_q;
        acc_d = acc_q;
        if (load) begin
            sgn_d = a_signed | b_signed;
        end
        if (acc_clr) begin
            acc_d = '0;
        end
        // Clear takes priority over the old total but not over the new product
        if (state_q == DONE) begin
            acc_d = acc_d + {{ACC_GUARD{sgn_q & product[2*N-1]}}, product};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sgn_q <= 1'b0;
            acc_q <= '0;
        end else begin
            sgn_q <= sgn_d;
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
`endif

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - self-checking bench for booth_seq_multiplier at N=4
module tb_booth_seq_multiplier;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           a_signed;
    logic           b_signed;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*N-1:0] result;
`ifdef BOOTH_MAC_EN
    logic           acc_clr;
    logic [2*N+3:0] acc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    booth_seq_multiplier #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .a_signed (a_signed),
        .b_signed (b_signed),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result)
`ifdef BOOTH_MAC_EN
        ,
        .acc_clr  (acc_clr),
        .acc      (acc)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] x, input logic [N-1:0] y,
                                                input logic xs, input logic ys);
        int ix;
        int iy;
        int p;
        ix = xs ? int'($signed(x)) : int'(x);
        iy = ys ? int'($signed(y)) : int'(y);
        p  = ix * iy;
        return p[2*N-1:0];
    endfunction

    // One isolated operation; operands are scrambled after accept to prove they are ignored
    task automatic do_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic xs, input logic ys, input string tag);
        int cyc;
        logic [2*N-1:0] exp;
        exp = ref_prod(x, y, xs, ys);
        @(negedge clk);
        a = x; b = y; a_signed = xs; b_signed = ys; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = N'($urandom); b = N'($urandom); a_signed = 1'($urandom); b_signed = 1'($urandom);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 20);
        check({tag, "_latency"}, cyc, N + 2);
        check({tag, "_result"}, result, exp);
        check({tag, "_ready"}, ready, 1'b1);
        @(negedge clk);
        check({tag, "_pulse"}, done, 1'b0);
        check({tag, "_held"}, result, exp);
    endtask

    task automatic apply_item(input int idx);
        a        = idx[3:0];
        b        = idx[7:4];
        a_signed = idx[8];
        b_signed = idx[9];
    endtask

    // Back-to-back sweep: start is held high so each new op is taken in the DONE cycle
    task automatic sweep();
        logic [2*N-1:0] expq[$];
        int nxt;
        int cyc;
        int it;
        @(negedge clk);
        apply_item(0);
        expq.push_back(ref_prod(a, b, a_signed, b_signed));
        start = 1'b1;
        @(negedge clk);
        nxt = 1;
        while (expq.size() > 0) begin
            if (nxt < 1024) begin
                it = nxt;
                apply_item(it);
                expq.push_back(ref_prod(a, b, a_signed, b_signed));
                nxt++;
            end else begin
                start = 1'b0;
            end
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!done && cyc < 20);
            check("sweep_gap", cyc, N + 2);
            check("sweep_result", result, expq.pop_front());
            if (cyc >= 20) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int pulses;
        logic [2*N-1:0] seen;
        rst = 1'b0; start = 1'b0; a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0;
`ifdef BOOTH_MAC_EN
        acc_clr = 1'b0;
`endif
        #1;
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_mul(4'h8, 4'h8, 1'b1, 1'b1, "neg8sq");
        do_mul(4'hF, 4'hF, 1'b0, 1'b0, "max_uns");
        do_mul(4'hF, 4'h3, 1'b1, 1'b0, "mixed");
        for (int i = 0; i < 30; i++) begin
            do_mul(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        sweep();

        // start and operand changes while busy must not disturb 3*5
        @(negedge clk);
        a = 4'd3; b = 4'd5; a_signed = 1'b0; b_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrun_busy", busy, 1'b1);
        start = 1'b1; a = 4'd7; b = 4'd7;
        repeat (2) @(negedge clk);
        start = 1'b0;
        pulses = 0;
        seen = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                seen = result;
            end
        end
        check("midrun_result", seen, 8'd15);
        check("midrun_pulses", pulses, 1);

        // reset during RUN aborts 5*5 silently
        @(negedge clk);
        a = 4'd5; b = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_result", result, '0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check("abort_result_held", result, '0);
        do_mul(4'd2, 4'd3, 1'b0, 1'b0, "after_abort");

`ifdef BOOTH_MAC_EN
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("mac_clr", acc, '0);
        do_mul(4'd3, 4'd4, 1'b0, 1'b0, "mac_a");
        check("mac_acc_12", acc, 12'd12);
        do_mul(4'hE, 4'd5, 1'b1, 1'b1, "mac_b");
        check("mac_acc_2", acc, 12'd2);
        @(negedge clk);
        a = 4'd7; b = 4'd7; a_signed = 1'b0; b_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        check("mac_clr_done", done, 1'b1);
        check("mac_acc_49", acc, 12'd49);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
